// File: rtl/sip_pkg.sv
// sip_pkg: shared lane geometry, FSM states and precision clamp for the bit-serial inner-product sequencer
package sip_pkg;
  localparam int LANES = 16;
  localparam int AW = 16;
  localparam int PSUM_W = 20;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  function automatic logic [4:0] clamp_p(input logic [4:0] cfg, input logic [4:0] bw);
    return (cfg == 5'd0 || cfg > bw) ? bw : cfg;
  endfunction
endpackage

// File: rtl/b16_sip_psum.sv
// b16_sip_psum: combinational AND-sum of one bit-plane across all lanes
module b16_sip_psum
  import sip_pkg::*;
(
  input  logic [LANES*AW-1:0] a,
  input  logic [LANES-1:0]    plane,
  output logic [PSUM_W-1:0]   psum
);
  always_comb begin
    psum = '0;
    for (int k = 0; k < LANES; k++) psum += plane[k] ? PSUM_W'(a[k*AW +: AW]) : '0;
  end
endmodule

// File: rtl/b16_sip_seq.sv
// b16_sip_seq: bit-serial 16-lane inner-product sequencer; feeds planes MSB-first
// into the AND-sum and owns the shift-accumulate register
module b16_sip_seq #(
  parameter int LANES = 16,
  parameter int AW = 16,
  parameter int BW = 8,
  parameter int OW = 32,
  parameter bit SIGNED_B = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*AW-1:0] in_a,
  input  logic [LANES*BW-1:0] in_b,
  input  logic [4:0]          cfg_prec,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OW-1:0]       out_data,
  output logic                busy
);
  import sip_pkg::*;
  state_t                state;
  logic [LANES*AW-1:0]   a_r;
  logic [LANES*BW-1:0]   b_r;
  logic [3:0]            cnt;
  logic [3:0]            pm1;
  logic [OW-1:0]         acc;
  logic [LANES-1:0]      plane;
  logic [PSUM_W-1:0]     psum;
  logic [OW-1:0]         psum_x;
  logic [4:0]            p_in;
  assign p_in = clamp_p(cfg_prec, 5'(BW));
  assign psum_x = OW'(psum);
  assign in_ready = state == IDLE && !rst;
  assign out_valid = state == HOLD;
  assign out_data = out_valid ? acc : '0;
  assign busy = state != IDLE;
  always_comb begin
    plane = '0;
    for (int k = 0; k < LANES; k++) plane[k] = b_r[k*BW + int'(cnt)];
  end
  b16_sip_psum u_psum (.a(a_r), .plane(plane), .psum(psum));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= in_a;
          b_r <= in_b;
          pm1 <= 4'(p_in - 5'd1);
          cnt <= 4'(p_in - 5'd1);
          acc <= '0;
          state <= RUN;
        end
        RUN: begin
          // the first plane of a two's-complement operand carries negative weight
          acc <= (SIGNED_B && cnt == pm1) ? '0 - psum_x : (acc << 1) + psum_x;
          cnt <= cnt == 4'd0 ? cnt : cnt - 4'd1;
          state <= cnt == 4'd0 ? HOLD : RUN;
        end
        HOLD: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_b16_sip_seq.sv
// tb_b16_sip_seq: scoreboard bench driving signed and unsigned sequencer instances in lockstep
module tb_b16_sip_seq;
  typedef struct packed {
    logic [31:0] s;
    logic [31:0] u;
    logic [4:0]  p;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [255:0] in_a = '0;
  logic [127:0] in_b = '0;
  logic [4:0] cfg_prec = '0;
  logic ir_s, ov_s, busy_s, ir_u, ov_u, busy_u;
  logic [31:0] od_s, od_u;
  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  always #5 clk = ~clk;
  b16_sip_seq #(.SIGNED_B(1'b1)) u_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_s), .in_a(in_a), .in_b(in_b),
    .cfg_prec(cfg_prec), .out_valid(ov_s), .out_ready(out_ready), .out_data(od_s), .busy(busy_s)
  );
  b16_sip_seq #(.SIGNED_B(1'b0)) u_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_u), .in_a(in_a), .in_b(in_b),
    .cfg_prec(cfg_prec), .out_valid(ov_u), .out_ready(out_ready), .out_data(od_u), .busy(busy_u)
  );
  function automatic logic [31:0] model(input logic [255:0] a, input logic [127:0] b, input logic [4:0] cp, input bit sgn);
    int p;
    logic [31:0] r;
    p = (cp == 0 || cp > 8) ? 8 : int'(cp);
    r = '0;
    for (int k = 0; k < 16; k++) begin
      logic [7:0] bb;
      longint v;
      bb = b[k*8 +: 8];
      v = 0;
      for (int i = 0; i < p; i++)
        if (bb[i]) v += (sgn && i == p - 1) ? -(longint'(1) << i) : (longint'(1) << i);
      r += 32'(longint'(a[k*16 +: 16]) * v);
    end
    return r;
  endfunction
  task automatic send(input logic [255:0] a, input logic [127:0] b, input logic [4:0] cp,
                      input logic [31:0] es, input logic [31:0] eu);
    int t = 0;
    in_a = a; in_b = b; cfg_prec = cp; in_valid = 1'b1;
    while (!ir_s && t < 100) begin @(posedge clk); #1; t++; end
    compared++;
    if (!ir_s) begin
      mismatched++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", ir_s);
      in_valid = 1'b0;
      return;
    end
    sb.push_back('{s: es, u: eu, p: (cp == 0 || cp > 8) ? 5'd8 : cp});
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = {8{$urandom}}; in_b = {4{$urandom}}; cfg_prec = 5'($urandom);
  endtask
  task automatic send_rand();
    logic [255:0] a;
    logic [127:0] b;
    logic [4:0] cp;
    a = {8{$urandom}}; b = {4{$urandom}}; cp = 5'($urandom_range(0, 10));
    send(a, b, cp, model(a, b, cp, 1'b1), model(a, b, cp, 1'b0));
  endtask
  task automatic collect(input int hold);
    exp_t e;
    int t = 1;
    logic [31:0] v0;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    while (!ov_s && t < 100) begin @(posedge clk); #1; t++; end
    compared++;
    if (!ov_s) begin
      mismatched++;
      $display("FAIL out_valid_timeout: out_valid=%0b required 1", ov_s);
      return;
    end
    compared++;
    if (t !== int'(e.p) + 1) begin mismatched++; $display("FAIL latency: got %0d cycles required %0d", t, e.p + 1); end
    v0 = od_s;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      compared++;
      if (ov_s !== 1'b1 || od_s !== v0 || ir_s !== 1'b0) begin
        mismatched++;
        $display("FAIL hold_stable: out_valid=%0b out_data=%h in_ready=%0b required 1 %h 0", ov_s, od_s, ir_s, v0);
      end
    end
    compared++;
    if (od_s !== e.s) begin mismatched++; $display("FAIL result_signed: got %h required %h", od_s, e.s); end
    compared++;
    if (ov_u !== 1'b1 || od_u !== e.u) begin mismatched++; $display("FAIL result_unsigned: valid=%0b got %h required %h", ov_u, od_u, e.u); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    compared++;
    if (ov_s !== 1'b0 || od_s !== 32'h0 || ir_s !== 1'b1 || busy_s !== 1'b0) begin
      mismatched++;
      $display("FAIL post_handshake: out_valid=%0b out_data=%h in_ready=%0b busy=%0b required 0 0 1 0", ov_s, od_s, ir_s, busy_s);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (ir_s !== 1'b0 || busy_s !== 1'b0 || ov_s !== 1'b0 || od_s !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_state: in_ready=%0b busy=%0b out_valid=%0b out_data=%h required 0 0 0 0", ir_s, busy_s, ov_s, od_s);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    compared++;
    if (ir_s !== 1'b1 || ir_u !== 1'b1) begin mismatched++; $display("FAIL reset_release: in_ready=%0b/%0b required 1", ir_s, ir_u); end
  endtask
  task automatic test_vectors();
    send({16{16'd1}}, {16{8'h01}}, 5'd8, 32'd16, 32'd16);
    collect(0);
    send({16{16'd3}}, {16{8'hFF}}, 5'd8, 32'hFFFF_FFD0, 32'd12240);
    collect(1);
    send(256'hFFFF << 80, 128'h7F << 40, 5'd8, 32'h007E_FF81, 32'h007E_FF81);
    collect(0);
  endtask
  task automatic test_clamp();
    send({16{16'd1}}, {16{8'h80}}, 5'd0, 32'hFFFF_F800, 32'd2048);
    collect(0);
    send({16{16'd2}}, {16{8'hF1}}, 5'd1, 32'hFFFF_FFE0, 32'd32);
    collect(0);
    send({16{16'd1}}, {16{8'h01}}, 5'd20, 32'd16, 32'd16);
    collect(0);
  endtask
  task automatic test_backpressure();
    send({16{16'd5}}, {16{8'h03}}, 5'd4, 32'd240, 32'd240);
    in_valid = 1'b1; in_a = {16{16'h1234}}; in_b = {16{8'h02}}; cfg_prec = 5'd8;
    collect(5);
    send({16{16'h1234}}, {16{8'h02}}, 5'd8, 32'h0002_4680, 32'h0002_4680);
    collect(0);
  endtask
  task automatic test_reset_mid_run();
    send({16{16'hABCD}}, {16{8'hC3}}, 5'd8, 32'h0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (ov_s !== 1'b0 || busy_s !== 1'b0 || ir_s !== 1'b0 || od_s !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_mid_run: out_valid=%0b busy=%0b in_ready=%0b out_data=%h required 0 0 0 0", ov_s, busy_s, ir_s, od_s);
    end
    if (sb.size() != 0) void'(sb.pop_back());
    rst = 1'b0;
    @(posedge clk); #1;
    send({16{16'd7}}, {16{8'h0A}}, 5'd8, 32'd1120, 32'd1120);
    collect(0);
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      send_rand();
      collect(i % 3);
    end
  endtask
  initial begin
    test_reset();
    test_vectors();
    test_clamp();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
